hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline hazard controller for a 5-stage in-order core.
//
// Detects load-use hazards, holds the front of the pipeline while a
// multi-cycle multiply/divide occupies EX, and squashes the wrong-path
// instructions behind a taken branch. Keeps two saturating statistics
// counters.
//
// Ports:
//   clock, reset              rising-edge clock, async active-low reset
//   id_rs1/id_rs2             ID-stage source registers
//   id_uses_rs1/id_uses_rs2   source actually read by the ID instruction
//   ex_rd, ex_mem_read        EX-stage destination and load flag
//   ex_is_muldiv              EX instruction is multiply/divide
//   branch_taken              EX resolved a taken branch/jump
//   pc_hold/ifid_hold/idex_hold        hold controls
//   ifid_flush/idex_flush/exmem_flush  bubble requests
//   md_busy                   multiply/divide still occupying EX
//   stall_cycles              saturating count of cycles with pc_hold=1
//   flush_events              saturating count of taken-branch flushes
module hazard_unit #(
  parameter int REG_W     = 4,
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_is_muldiv,
  input  logic             branch_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {IDLE, MD_BUSY, FLUSH} state_t;

  // MD_BUSY covers the held cycles after the one spent in IDLE.
  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       supp_q, supp_d;   // blocks re-trigger by the same muldiv
  logic       flush_inc;
  logic       load_use;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    supp_d      = 1'b0;
    flush_inc   = 1'b0;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_busy     = 1'b0;
    // Outputs are gated by reset so they drop the instant reset asserts,
    // even if inputs would otherwise raise them from IDLE.
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            state_d    = FLUSH;
          end else if (ex_is_muldiv && !supp_q) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
            if (MD_LOAD == 4'd0) begin
              // Only one held cycle: go straight to the suppressed IDLE.
              supp_d = 1'b1;
            end else begin
              state_d = MD_BUSY;
              cnt_d   = MD_LOAD;
            end
          end else if (load_use) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_hold   = 1'b1;
          exmem_flush = 1'b1;
          md_busy     = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            supp_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      supp_q       <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      supp_q  <= supp_d;
      if (pc_hold && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + 1'b1;
      if (flush_inc && (flush_events != CNT_MAX))
        flush_events <= flush_events + 1'b1;
    end
  end

endmodule
